// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (instruction fetch F, data D) single-port memory
//               arbiter with round-robin tie-break, latched request fields,
//               registered memory-side strobes and a busy-cycle timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iF_Req,
   input  logic        iD_Req,
   input  logic [31:0] iF_Addr,
   input  logic [31:0] iD_Addr,
   input  logic        iD_Write,
   input  logic [31:0] iD_Data,
   output logic        oF_Done,
   output logic        oD_Done,
   output logic [31:0] oF_Data,
   output logic [31:0] oD_Data,
   output logic        oErr,
   output logic [31:0] oMemAddr,
   output logic [31:0] oMemData,
   output logic        oMemRead,
   output logic        oMemWrite,
   input  logic [31:0] iMemData,
   input  logic        iMemRdy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_F = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   // Last granted requester: 0 = F, 1 = D.
   localparam logic GNT_F = 1'b0;
   localparam logic GNT_D = 1'b1;

   // Counter value at which a still-unacknowledged access is abandoned.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      next_state;
   logic        last_gnt;
   logic [7:0]  busy_cnt;
   logic        lat_write;
   logic        grant_f;
   logic        grant_d;
   logic        finish_ok;
   logic        finish_to;

   // Next-state logic: arbitration in IDLE, completion/timeout in BUSY.
   always_comb begin
      next_state = state;
      grant_f    = 1'b0;
      grant_d    = 1'b0;
      finish_ok  = 1'b0;
      finish_to  = 1'b0;
      case (state)
         IDLE: begin
            if (iF_Req && iD_Req) begin
               // Tie: serve whoever did not get the previous grant.
               if (last_gnt == GNT_F) begin
                  grant_d = 1'b1;
               end else begin
                  grant_f = 1'b1;
               end
            end else if (iF_Req) begin
               grant_f = 1'b1;
            end else if (iD_Req) begin
               grant_d = 1'b1;
            end
            if (grant_f) begin
               next_state = BUSY_F;
            end else if (grant_d) begin
               next_state = BUSY_D;
            end
         end
         BUSY_F, BUSY_D: begin
            // Ready takes priority over a timeout landing in the same cycle.
            if (iMemRdy) begin
               finish_ok  = 1'b1;
               next_state = IDLE;
            end else if (busy_cnt == TO_LAST) begin
               finish_to  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Datapath: request latching, memory strobes, completion pulses, read data.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         last_gnt  <= GNT_F;
         busy_cnt  <= 8'd0;
         lat_write <= 1'b0;
         oMemAddr  <= 32'd0;
         oMemData  <= 32'd0;
         oMemRead  <= 1'b0;
         oMemWrite <= 1'b0;
         oF_Done   <= 1'b0;
         oD_Done   <= 1'b0;
         oErr      <= 1'b0;
         oF_Data   <= 32'd0;
         oD_Data   <= 32'd0;
      end else begin
         oF_Done <= 1'b0;
         oD_Done <= 1'b0;
         oErr    <= 1'b0;

         if (grant_f) begin
            last_gnt  <= GNT_F;
            busy_cnt  <= 8'd0;
            lat_write <= 1'b0;
            oMemAddr  <= iF_Addr;
            oMemRead  <= 1'b1;
            oMemWrite <= 1'b0;
         end else if (grant_d) begin
            last_gnt  <= GNT_D;
            busy_cnt  <= 8'd0;
            lat_write <= iD_Write;
            oMemAddr  <= iD_Addr;
            oMemData  <= iD_Data;
            oMemRead  <= ~iD_Write;
            oMemWrite <= iD_Write;
         end

         if (finish_ok || finish_to) begin
            oMemRead  <= 1'b0;
            oMemWrite <= 1'b0;
            oErr      <= finish_to;
            if (state == BUSY_F) begin
               oF_Done <= 1'b1;
               if (finish_ok) begin
                  oF_Data <= iMemData;
               end
            end else begin
               oD_Done <= 1'b1;
               if (finish_ok && !lat_write) begin
                  oD_Data <= iMemData;
               end
            end
         end else if (state != IDLE) begin
            busy_cnt <= busy_cnt + 8'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed-vector bench for mem_arbiter with a completion
//               scoreboard (expected Done/Err/Data queued by the stimulus,
//               popped by an independent monitor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic        iClk = 1'b0;
   logic        iRst;
   logic        iF_Req, iD_Req;
   logic [31:0] iF_Addr, iD_Addr;
   logic        iD_Write;
   logic [31:0] iD_Data;
   logic        oF_Done, oD_Done;
   logic [31:0] oF_Data, oD_Data;
   logic        oErr;
   logic [31:0] oMemAddr, oMemData;
   logic        oMemRead, oMemWrite;
   logic [31:0] iMemData;
   logic        iMemRdy;

   typedef struct {
      logic        is_d;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   mem_arbiter #(.TIMEOUT(4)) dut (
      .iClk(iClk), .iRst(iRst),
      .iF_Req(iF_Req), .iD_Req(iD_Req),
      .iF_Addr(iF_Addr), .iD_Addr(iD_Addr),
      .iD_Write(iD_Write), .iD_Data(iD_Data),
      .oF_Done(oF_Done), .oD_Done(oD_Done),
      .oF_Data(oF_Data), .oD_Data(oD_Data),
      .oErr(oErr),
      .oMemAddr(oMemAddr), .oMemData(oMemData),
      .oMemRead(oMemRead), .oMemWrite(oMemWrite),
      .iMemData(iMemData), .iMemRdy(iMemRdy)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic push(input logic is_d, input logic err, input logic [31:0] data);
      exp_t e;
      e.is_d = is_d;
      e.err  = err;
      e.data = data;
      sb.push_back(e);
   endtask

   // Monitor: every Done pulse is matched against the oldest expectation.
   always @(negedge iClk) begin
      if (oF_Done || oD_Done) begin
         chk("single_done", {31'd0, oF_Done & oD_Done}, 32'd0);
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got F=%0b D=%0b expected none", oF_Done, oD_Done);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_owner", {31'd0, oD_Done}, {31'd0, e.is_d});
            chk("done_err", {31'd0, oErr}, {31'd0, e.err});
            chk("done_data", e.is_d ? oD_Data : oF_Data, e.data);
         end
      end else if (oErr) begin
         n_checks++;
         $display("FAIL err_without_done: got oErr=1 expected 0");
      end
   end

   initial begin
      iRst = 1'b1;
      iF_Req = 1'b1; iD_Req = 1'b1;        // requests during reset are ignored
      iF_Addr = 32'h0; iD_Addr = 32'h0;
      iD_Write = 1'b0; iD_Data = 32'h0;
      iMemData = 32'hFFFF_FFFF; iMemRdy = 1'b1;
      tick(); tick();
      @(negedge iClk);
      chk("rst_read", {31'd0, oMemRead}, 32'd0);
      chk("rst_write", {31'd0, oMemWrite}, 32'd0);
      chk("rst_addr", oMemAddr, 32'd0);
      chk("rst_mdata", oMemData, 32'd0);
      chk("rst_fdata", oF_Data, 32'd0);
      chk("rst_ddata", oD_Data, 32'd0);
      tick();
      iRst = 1'b0; iF_Req = 1'b0; iD_Req = 1'b0; iMemRdy = 1'b0;
      tick();

      // F read, ready immediately.
      iF_Req = 1'b1; iF_Addr = 32'h100; iMemRdy = 1'b1; iMemData = 32'hDEADBEEF;
      push(1'b0, 1'b0, 32'hDEADBEEF);
      tick();
      iF_Req = 1'b0; iF_Addr = 32'h0;
      @(negedge iClk);
      chk("f_read_strobe", {30'd0, oMemRead, oMemWrite}, 32'd2);
      chk("f_read_addr", oMemAddr, 32'h100);
      tick();
      iMemRdy = 1'b0;
      @(negedge iClk);
      chk("f_read_strobe_off", {30'd0, oMemRead, oMemWrite}, 32'd0);
      tick();

      // D write, memory ready after three wait cycles.
      iD_Req = 1'b1; iD_Write = 1'b1; iD_Addr = 32'h40; iD_Data = 32'h12345678;
      push(1'b1, 1'b0, 32'h0);
      tick();
      iD_Req = 1'b0; iD_Data = 32'hBAD0BAD0; iD_Addr = 32'h0; iD_Write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iMemRdy = (i == 3);
         @(negedge iClk);
         chk("d_write_strobe", {30'd0, oMemRead, oMemWrite}, 32'd1);
         chk("d_write_mdata", oMemData, 32'h12345678);
         chk("d_write_addr", oMemAddr, 32'h40);
         tick();
      end
      iMemRdy = 1'b0;
      @(negedge iClk);
      chk("d_write_strobe_off", {30'd0, oMemRead, oMemWrite}, 32'd0);
      chk("idle_mdata_hold", oMemData, 32'h12345678);
      tick();

      // Timeout race: ready arrives in the 4th busy cycle.
      iD_Req = 1'b1; iD_Write = 1'b0; iD_Addr = 32'h80;
      push(1'b1, 1'b0, 32'hCAFEF00D);
      tick();
      iD_Req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iMemRdy = (i == 3);
         iMemData = (i == 3) ? 32'hCAFEF00D : 32'h0;
         @(negedge iClk);
         chk("race_strobe", {30'd0, oMemRead, oMemWrite}, 32'd2);
         tick();
      end
      iMemRdy = 1'b0;
      tick();

      // Timeout: ready never arrives; data must stay unchanged.
      iD_Req = 1'b1; iD_Addr = 32'h84; iMemData = 32'h11111111;
      push(1'b1, 1'b1, 32'hCAFEF00D);
      tick();
      iD_Req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge iClk);
         chk("to_strobe", {30'd0, oMemRead, oMemWrite}, 32'd2);
         chk("to_addr", oMemAddr, 32'h84);
         tick();
      end
      @(negedge iClk);
      chk("to_strobe_off", {30'd0, oMemRead, oMemWrite}, 32'd0);
      tick();

      // Reset mid-transaction: no Done, everything cleared.
      iF_Req = 1'b1; iF_Addr = 32'h500;
      tick();
      iF_Req = 1'b0;
      @(negedge iClk);
      chk("mid_strobe", {30'd0, oMemRead, oMemWrite}, 32'd2);
      iRst = 1'b1;
      tick();
      iRst = 1'b0;
      @(negedge iClk);
      chk("mid_rst_strobe", {30'd0, oMemRead, oMemWrite}, 32'd0);
      chk("mid_rst_addr", oMemAddr, 32'd0);
      chk("mid_rst_fdata", oF_Data, 32'd0);
      chk("mid_rst_ddata", oD_Data, 32'd0);
      chk("mid_rst_mdata", oMemData, 32'd0);
      tick();

      // Contention after reset: D wins first tie, then alternation.
      iF_Req = 1'b1; iF_Addr = 32'h200;
      iD_Req = 1'b1; iD_Addr = 32'h300; iD_Write = 1'b0;
      iMemRdy = 1'b1;
      push(1'b1, 1'b0, 32'h1000);
      push(1'b0, 1'b0, 32'h1002);
      push(1'b1, 1'b0, 32'h1004);
      push(1'b0, 1'b0, 32'h1006);
      tick();
      for (int k = 0; k < 8; k++) begin
         iMemData = 32'h1000 + k;
         if (k == 7) begin
            iF_Req = 1'b0;
            iD_Req = 1'b0;
         end
         @(negedge iClk);
         if (k % 2 == 0) begin
            chk("cont_strobe", {30'd0, oMemRead, oMemWrite}, 32'd2);
            chk("cont_addr", oMemAddr, (k % 4 == 0) ? 32'h300 : 32'h200);
         end else begin
            chk("cont_idle", {30'd0, oMemRead, oMemWrite}, 32'd0);
         end
         tick();
      end
      iMemRdy = 1'b0;
      tick(); tick();
      chk("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of busy cycles waited for iMemRdy before abort (range 1..255).
REQ-002 SHALL have port iClk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port iRst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports iF_Req, input, 1, and iD_Req, input, 1, request strobes for the instruction-fetch (F) and data (D) requesters.
REQ-005 SHALL have ports iF_Addr, input, 32, and iD_Addr, input, 32, request word addresses.
REQ-006 SHALL have ports iD_Write, input, 1, and iD_Data, input, 32, for the data write flag and write data; F requests are always reads.
REQ-007 SHALL have ports oF_Done, output, 1, and oD_Done, output, 1, one-cycle completion pulses.
REQ-008 SHALL have ports oF_Data, output, 32, and oD_Data, output, 32, registered read data.
REQ-009 SHALL have port oErr, output, 1, a one-cycle pulse that accompanies Done when the transaction timed out.
REQ-010 SHALL have ports oMemAddr, output, 32, oMemData, output, 32, oMemRead, output, 1, and oMemWrite, output, 1, as registered memory-side outputs.
REQ-011 SHALL have ports iMemData, input, 32, and iMemRdy, input, 1, for memory read data and the ready/acknowledge signal.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_F and BUSY_D.
REQ-013 In IDLE, when exactly one request is high, SHALL move to the matching BUSY state on the next edge.
REQ-014 In IDLE, when both requests are high, SHALL grant the requester not granted last (round-robin via a lastGnt flop, reset value F, so D wins the first tie).
REQ-015 On grant, SHALL latch address, write flag and write data into internal registers; requesters may change or drop inputs after the grant edge.
REQ-016 SHALL drive oMemAddr, oMemData, oMemRead and oMemWrite from the latched values from the first BUSY cycle until the completing edge, exactly one strobe high.
REQ-017 SHALL drive both strobes low in IDLE, with oMemAddr and oMemData holding their last values.
REQ-018 In BUSY, on a cycle with iMemRdy=1, SHALL on the next edge: return to IDLE; pulse the granted Done for one cycle; capture iMemData into the granted Data register for a read; leave the Data register unchanged for a write.
REQ-019 iMemRdy SHALL be ignored in IDLE.
REQ-020 SHALL have an 8-bit busy counter that clears on grant and increments each BUSY cycle with iMemRdy=0.
REQ-021 When the counter equals TIMEOUT-1 with iMemRdy=0, SHALL on the next edge return to IDLE, pulse the granted Done together with oErr, and leave Data unchanged.
REQ-022 When iMemRdy=1 in the timeout cycle, SHALL complete normally (ready wins).
REQ-023 Minimum latency SHALL be: request sampled at edge N, strobe high in cycle N+1, iMemRdy in cycle N+1 gives Done in cycle N+2 and IDLE in N+2; the earliest next grant is at edge N+2, so strobes are visible again in N+3.
REQ-024 A request held high after its Done SHALL be treated as a new request.
REQ-025 SHALL keep oF_Done, oD_Done and oErr mutually consistent: never both Done high in the same cycle; oErr only with a Done.

Reset
REQ-026 While iRst=1 at an edge, SHALL set state to IDLE, lastGnt to F, counter to 0, and all outputs (strobes, Done, oErr, Data, oMemAddr, oMemData) to 0.
REQ-027 A reset mid-transaction SHALL abort it without a Done pulse; strobes are low from the cycle after the reset edge.
REQ-028 Requests present during reset SHALL be ignored; arbitration starts at the first edge with iRst=0.

Verification
REQ-029 F read: iF_Req=1, iF_Addr=0x100, iMemRdy=1 one cycle later, iMemData=0xDEADBEEF -> oMemRead=1 with oMemAddr=0x100 for 1 cycle, oF_Done pulse, oF_Data=0xDEADBEEF, oErr=0.
REQ-030 D write: iD_Req=1, iD_Write=1, iD_Addr=0x40, iD_Data=0x12345678, memory ready after 3 cycles -> oMemWrite high 4 cycles with oMemData=0x12345678, oD_Done pulse, oD_Data unchanged.
REQ-031 Contention: both requests held high continuously, ready immediately -> grants alternate D,F,D,F; no cycle with both Done high.
REQ-032 Timeout: TIMEOUT=4, D read, iMemRdy held 0 -> strobe high exactly 4 cycles, then oD_Done=1 and oErr=1 together, state IDLE.
REQ-033 Timeout race: TIMEOUT=4, iMemRdy=1 in the 4th busy cycle -> normal completion, oErr=0, data captured.
REQ-034 Reset mid-op: F read in progress, iRst=1 for one cycle -> strobes 0 next cycle, no oF_Done, all outputs 0, next request serviced normally.
